// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared constants and state encoding for the decoder scan sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package decoder_scan_sequencer_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/decoder_scan_sequencer_next_enabled_channel.sv
// Finds the next enabled channel strictly above cur, plus the lowest enabled channel.
// Latency: purely combinational.
// Backpressure: none.
module decoder_scan_sequencer_next_enabled_channel
  import decoder_scan_sequencer_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  next_ch,
  output logic              found,
  output logic [SEL_W-1:0]  lowest_ch
);

  // Walk from the top channel down so the last hit is the lowest qualifying one.
  always_comb begin
    next_ch   = '0;
    found     = 1'b0;
    lowest_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest_ch = SEL_W'(i);
        if (i > int'(cur)) begin
          next_ch = SEL_W'(i);
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Steps a 3-bit decoder select through enabled channels, holding each for dwell+1 cycles.
// Latency: first valid sel one cycle after an accepted start; no gap cycles between channels.
// Backpressure: none; start is ignored while scanning, stop aborts at any time.
module decoder_scan_sequencer
  import decoder_scan_sequencer_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  state_t             state;
  logic [NUM_CH-1:0]  mask_q;
  logic               cont_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt;

  logic [NUM_CH-1:0]  search_mask;
  logic [SEL_W-1:0]   next_ch;
  logic               next_found;
  logic [SEL_W-1:0]   lowest_ch;

  // In IDLE the search looks at the incoming mask to pick the first channel;
  // while scanning it only ever sees the latched mask.
  always_comb begin
    search_mask = (state == ST_IDLE) ? ch_mask : mask_q;
  end

  decoder_scan_sequencer_next_enabled_channel u_next (
    .mask      (search_mask),
    .cur       (sel),
    .next_ch   (next_ch),
    .found     (next_found),
    .lowest_ch (lowest_ch)
  );

  // Scan FSM with registered outputs; done/wrap default low so they pulse for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mask_q    <= '0;
      cont_q    <= 1'b0;
      dwell_q   <= '0;
      cnt       <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !stop && (ch_mask != '0)) begin
            mask_q    <= ch_mask;
            cont_q    <= continuous;
            dwell_q   <= dwell;
            cnt       <= dwell;
            sel       <= lowest_ch;
            sel_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (stop) begin
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= ST_IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else begin
            cnt <= dwell_q;
            if (next_found) begin
              sel <= next_ch;
            end else if (cont_q) begin
              sel  <= lowest_ch;
              wrap <= 1'b1;
            end else begin
              // sel keeps the last channel so downstream sees a stable value.
              sel_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed and soak stimulus against a list/arithmetic model of the scan sequencer.
// Latency: model expects first valid sel one cycle after an accepted start.
// Backpressure: n/a.
module tb_decoder_scan_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       continuous;
  logic [7:0] ch_mask;
  logic [7:0] dwell;
  logic [2:0] sel;
  logic       sel_valid;
  logic       busy;
  logic       done;
  logic       wrap;

  int checks   = 0;
  int failures = 0;

  decoder_scan_sequencer #(.DWELL_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .ch_mask    (ch_mask),
    .dwell      (dwell),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .busy       (busy),
    .done       (done),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A scan is a list of enabled channels; cycle t of the scan shows
  // list[(t / (dwell+1)) % n]. A pass is n*(dwell+1) cycles long.
  logic       m_init = 1'b0;
  logic       m_active = 1'b0;
  int         m_list[8];
  int         m_n, m_d, m_t;
  logic       m_cont;
  logic [7:0] m_mask = 8'h00;
  logic [2:0] e_sel;
  logic       e_valid, e_busy, e_done, e_wrap;

  always @(posedge clk) begin
    if (rst) begin
      m_init   = 1'b1;
      m_active = 1'b0;
      m_mask   = 8'h00;
      e_sel    = 3'd0;
      e_valid  = 1'b0;
      e_busy   = 1'b0;
      e_done   = 1'b0;
      e_wrap   = 1'b0;
    end else if (m_init) begin
      e_done = 1'b0;
      e_wrap = 1'b0;
      if (!m_active) begin
        if (start && !stop && ch_mask != 8'h00) begin
          m_n = 0;
          for (int i = 0; i < 8; i++)
            if (ch_mask[i]) begin m_list[m_n] = i; m_n++; end
          m_d      = int'(dwell);
          m_cont   = continuous;
          m_mask   = ch_mask;
          m_t      = 0;
          m_active = 1'b1;
          e_sel    = 3'(m_list[0]);
          e_valid  = 1'b1;
          e_busy   = 1'b1;
        end
      end else if (stop) begin
        m_active = 1'b0;
        e_valid  = 1'b0;
        e_busy   = 1'b0;
        e_done   = 1'b1;
      end else begin
        m_t++;
        if (!m_cont && m_t == m_n * (m_d + 1)) begin
          m_active = 1'b0;
          e_valid  = 1'b0;
          e_busy   = 1'b0;
          e_done   = 1'b1;
        end else begin
          e_sel  = 3'(m_list[(m_t / (m_d + 1)) % m_n]);
          e_wrap = m_cont && (m_t % (m_n * (m_d + 1)) == 0);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("cmp_sel", int'(sel), int'(e_sel));
      chk("cmp_sel_valid", int'(sel_valid), int'(e_valid));
      chk("cmp_busy", int'(busy), int'(e_busy));
      chk("cmp_done", int'(done), int'(e_done));
      chk("cmp_wrap", int'(wrap), int'(e_wrap));
      if (sel_valid === 1'b1)
        chk("inv_mask_sel", int'(m_mask[sel]), 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [7:0] m, input logic [7:0] d, input logic c);
    ch_mask    = m;
    dwell      = d;
    continuous = c;
    start      = 1'b1;
    cyc(1);
    start      = 1'b0;
  endtask

  // Counts busy cycles until done, bounded so a stuck DUT still reaches the summary.
  task automatic wait_done(input string name, input int exp_len);
    int len = 0;
    bit seen = 0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      if (done) seen = 1;
      else begin
        if (busy) len++;
        cyc(1);
      end
    end
    chk({name, "_done_seen"}, int'(seen), 1);
    chk({name, "_pass_len"}, len, exp_len);
  endtask

  int seq2[13] = '{2, 2, 2, 5, 5, 5, 7, 7, 7, 2, 2, 2, 5};

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    ch_mask = 8'h00; dwell = 8'd0;
    cyc(2);
    chk("rst_sel", int'(sel), 0);
    chk("rst_valid", int'(sel_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wrap", int'(wrap), 0);
    rst = 1'b0;
    cyc(1);

    // Full mask, dwell 0, single shot: 0..7 on consecutive cycles, then done.
    do_start(8'hFF, 8'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("ff_sel", int'(sel), i);
      chk("ff_busy", int'(busy), 1);
      cyc(1);
    end
    chk("ff_done", int'(done), 1);
    chk("ff_busy_low", int'(busy), 0);
    chk("ff_valid_low", int'(sel_valid), 0);
    chk("ff_sel_hold", int'(sel), 7);
    cyc(1);
    chk("ff_done_pulse", int'(done), 0);

    // Sparse mask, dwell 2, continuous: 2,5,7 held 3 cycles each, wrap on 7->2.
    do_start(8'b1010_0100, 8'd2, 1'b1);
    for (int i = 0; i < 13; i++) begin
      chk("cont_sel", int'(sel), seq2[i]);
      chk("cont_wrap", int'(wrap), (i == 9) ? 1 : 0);
      chk("cont_nodone", int'(done), 0);
      if (i < 12) cyc(1);
    end
    // Input changes and a start during the scan are ignored.
    do_start(8'h01, 8'd0, 1'b0);
    cyc(6);
    chk("midscan_busy", int'(busy), 1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("stop_busy", int'(busy), 0);
    chk("stop_valid", int'(sel_valid), 0);
    chk("stop_done", int'(done), 1);
    // start and stop together in IDLE do nothing.
    ch_mask = 8'hFF; start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", int'(busy), 0);
    chk("startstop_done", int'(done), 0);

    // Empty mask start is ignored.
    do_start(8'h00, 8'd1, 1'b0);
    chk("zero_busy", int'(busy), 0);
    cyc(1);
    chk("zero_done", int'(done), 0);

    // Single channel, single shot: sel=4 for 4 cycles then done.
    do_start(8'h10, 8'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("one_sel", int'(sel), 4);
      cyc(1);
    end
    chk("one_done", int'(done), 1);
    cyc(1);

    // Single channel continuous: wrap every 2 cycles, sel fixed.
    do_start(8'h08, 8'd1, 1'b1);
    cyc(7);
    stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(1);

    // Reset mid-scan: outputs clear with no done pulse, then a normal scan.
    do_start(8'hFF, 8'd3, 1'b0);
    cyc(5);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mrst_sel", int'(sel), 0);
    chk("mrst_valid", int'(sel_valid), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_done", int'(done), 0);
    chk("mrst_wrap", int'(wrap), 0);
    cyc(1);
    do_start(8'b0100_0010, 8'd1, 1'b0);
    wait_done("after_rst", 4);
    cyc(1);

    // Soak: random single-shot passes, then continuous scans cut by stop.
    for (int s = 0; s < 20; s++) begin
      logic [7:0] m;
      logic [7:0] d;
      m = 8'($urandom_range(1, 255));
      d = 8'($urandom_range(0, 5));
      do_start(m, d, 1'b0);
      wait_done("soak", $countones(m) * (int'(d) + 1));
      cyc(1 + int'($urandom_range(0, 2)));
    end
    for (int s = 0; s < 6; s++) begin
      do_start(8'($urandom_range(1, 255)), 8'($urandom_range(0, 3)), 1'b1);
      cyc(int'($urandom_range(5, 60)));
      stop = 1'b1; cyc(1); stop = 1'b0;
      chk("soak_stop_done", int'(done), 1);
      cyc(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
